// File: rtl/cache_control_pkg.sv
// cache_ctrl_pkg: FSM state encoding and datapath mux select constants for cache_control.
package cache_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FETCH, INSTALL} state_e;

    localparam logic DWMUX_FILL    = 1'b0;
    localparam logic DWMUX_STORE   = 1'b1;
    localparam logic PMADDR_CPU    = 1'b0;
    localparam logic PMADDR_VICTIM = 1'b1;
    localparam logic ADMUX_ARRAY   = 1'b0;
    localparam logic ADMUX_PMDR    = 1'b1;

endpackage

// File: rtl/cache_control_if.sv
// cache_control_if: CPU, physical-memory and datapath control/status signals around the cache controller.
interface cache_control_if;

    logic mem_read, mem_write, hit, eviction, pmem_resp;
    logic mem_resp, pmem_read, pmem_write, array_read, array_load, lru_load, dirty_load;
    logic pmdr_load, datawritemux_sel, adaptermux_sel, pmemaddrmux_sel;

    modport master (
        input  mem_read, mem_write, hit, eviction, pmem_resp,
        output mem_resp, pmem_read, pmem_write, array_read, array_load, lru_load, dirty_load,
               pmdr_load, datawritemux_sel, adaptermux_sel, pmemaddrmux_sel
    );

    modport slave (
        output mem_read, mem_write, hit, eviction, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, array_read, array_load, lru_load, dirty_load,
               pmdr_load, datawritemux_sel, adaptermux_sel, pmemaddrmux_sel
    );

endinterface

// File: rtl/cache_control_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, synchronous active-high clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    assign count_d = (inc_i && count_q != '1) ? count_q + 1'b1 : count_q;
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/cache_control.sv
// cache_control: control FSM for the 2-way, 8-set cache datapath with writeback/fill sequencing
// and saturating hit/miss/writeback counters.
module cache_control
    import cache_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_control_if.master      bus,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    state_e state_q, state_d;
    logic   replay_q, replay_d;
    logic   req, hit_inc, miss_inc, wb_inc;

    assign req = bus.mem_read | bus.mem_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            replay_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            replay_q <= replay_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        replay_d             = replay_q;
        hit_inc              = 1'b0;
        miss_inc             = 1'b0;
        wb_inc               = 1'b0;
        bus.mem_resp         = 1'b0;
        bus.pmem_read        = 1'b0;
        bus.pmem_write       = 1'b0;
        bus.array_read       = 1'b0;
        bus.array_load       = 1'b0;
        bus.lru_load         = 1'b0;
        bus.dirty_load       = 1'b0;
        bus.pmdr_load        = 1'b0;
        bus.datawritemux_sel = DWMUX_FILL;
        bus.adaptermux_sel   = ADMUX_ARRAY;
        bus.pmemaddrmux_sel  = PMADDR_CPU;
        if (!rst) begin
            bus.array_read = 1'b1;
            case (state_q)
                IDLE: state_d = req ? LOOKUP : IDLE;
                LOOKUP: begin
                    if (!req) begin
                        state_d  = IDLE;
                        replay_d = 1'b0;
                    end else if (bus.hit) begin
                        // mem_write wins when both request lines are high
                        bus.mem_resp         = 1'b1;
                        bus.lru_load         = 1'b1;
                        bus.array_load       = bus.mem_write;
                        bus.dirty_load       = bus.mem_write;
                        bus.datawritemux_sel = bus.mem_write ? DWMUX_STORE : DWMUX_FILL;
                        hit_inc              = !replay_q;
                        state_d              = IDLE;
                        replay_d             = 1'b0;
                    end else begin
                        miss_inc = !replay_q;
                        state_d  = bus.eviction ? WRITEBACK : FETCH;
                    end
                end
                WRITEBACK: begin
                    bus.pmem_write      = 1'b1;
                    bus.pmemaddrmux_sel = PMADDR_VICTIM;
                    wb_inc              = bus.pmem_resp;
                    state_d             = bus.pmem_resp ? FETCH : WRITEBACK;
                end
                FETCH: begin
                    bus.pmem_read = 1'b1;
                    bus.pmdr_load = bus.pmem_resp;
                    state_d       = bus.pmem_resp ? INSTALL : FETCH;
                end
                INSTALL: begin
                    bus.array_load = 1'b1;
                    bus.dirty_load = 1'b1;
                    replay_d       = 1'b1;
                    state_d        = LOOKUP;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_WIDTH)) u_hit  (.clk(clk), .rst(rst), .inc_i(hit_inc),  .count_o(hit_count));
    sat_counter #(.W(CNT_WIDTH)) u_miss (.clk(clk), .rst(rst), .inc_i(miss_inc), .count_o(miss_count));
    sat_counter #(.W(CNT_WIDTH)) u_wb   (.clk(clk), .rst(rst), .inc_i(wb_inc),   .count_o(wb_count));

endmodule

// File: doc/cache_control.md
Name: cache_control

Overview:
- Control FSM that sequences the 2-way, 8-set, 32-byte-line cache datapath.
- Decodes the CPU request and the datapath `hit`/`eviction` status into array/LRU/dirty load strobes, mux selects and the physical-memory read/write handshake.
- Sits between the CPU memory port and physical memory, alongside the datapath, inside the cache top level.
- Also maintains saturating hit/miss/writeback performance counters.

Parameters:
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- hit  in  1  datapath: valid tag match in the addressed set
- eviction  in  1  datapath: LRU way of the addressed set is dirty
- pmem_resp  in  1  physical memory transaction complete
- mem_resp  out  1  one-cycle CPU completion pulse
- pmem_read  out  1  physical memory line read request
- pmem_write  out  1  physical memory line write request
- array_read  out  1  arrays read enable
- array_load  out  1  valid/tag/data write strobe (way chosen by datapath)
- lru_load  out  1  LRU update strobe
- dirty_load  out  1  dirty-bit write strobe
- pmdr_load  out  1  capture pmem_rdata into line buffer
- datawritemux_sel  out  1  0 = line buffer (fill), 1 = adapter write data (store)
- adaptermux_sel  out  1  0 = array read data, 1 = line buffer
- pmemaddrmux_sel  out  1  0 = CPU address, 1 = victim address {tag_lru, set, 5'b0}
- hit_count  out  CNT_WIDTH  first-lookup hits
- miss_count  out  CNT_WIDTH  first-lookup misses
- wb_count  out  CNT_WIDTH  dirty writebacks issued

Behaviour:
- States: IDLE, LOOKUP, WRITEBACK, FETCH, INSTALL.
- Outputs are combinational from state plus inputs.
- Outputs default to 0 in every state. array_read = 1 in every state while rst = 0. adaptermux_sel = 0 in all states (reserved for critical-word forwarding).
- rst = 1: state <= IDLE, replay flag <= 0, counters <= 0. All control outputs are 0 in the reset cycle.
- Reset mid-miss drops pmem_read/pmem_write from the next cycle. No mem_resp is issued for the aborted request.
- IDLE:
  - mem_read | mem_write -> LOOKUP; otherwise stay.
  - Arrays read the set during this cycle.
- LOOKUP:
  - No request present (dropped) -> IDLE, no strobes.
  - Hit, read: mem_resp = 1, lru_load = 1 -> IDLE.
  - Hit, write: array_load = 1, datawritemux_sel = 1, dirty_load = 1, lru_load = 1, mem_resp = 1 -> IDLE.
  - Miss with eviction = 1 -> WRITEBACK; miss with eviction = 0 -> FETCH.
  - mem_read & mem_write together: treated as a write.
- WRITEBACK: pmem_write = 1, pmemaddrmux_sel = 1. Hold until pmem_resp, then -> FETCH. The transaction is never abandoned, even if the CPU request drops.
- FETCH: pmem_read = 1, pmemaddrmux_sel = 0, pmdr_load = pmem_resp. On pmem_resp -> INSTALL.
- INSTALL:
  - array_load = 1, datawritemux_sel = 0, dirty_load = 1. Dirty becomes mem_write; clean for read misses.
  - Set replay flag -> LOOKUP.
  - The replayed LOOKUP is guaranteed to hit and completes the access.
- Replay flag: cleared on every LOOKUP exit to IDLE.
- Counters:
  - Update only in LOOKUP with replay flag = 0 and a request present: hit_count++ on hit, miss_count++ on miss.
  - wb_count++ on the WRITEBACK -> FETCH transition.
  - All counters saturate at all-ones.
- Latency, counted from the cycle the request is first seen in IDLE:
  - Hit: mem_resp in cycle 2.
  - Clean miss: 2 + F + 2 cycles, F = FETCH cycles including the pmem_resp cycle.
  - Dirty miss: adds W WRITEBACK cycles.
- pmem_read and pmem_write are never asserted together. Each stays high continuously until pmem_resp.

Decomposition:
- Package cache_ctrl_pkg holds:
  - state enum (IDLE, LOOKUP, WRITEBACK, FETCH, INSTALL);
  - select constants DWMUX_FILL = 0, DWMUX_STORE = 1, PMADDR_CPU = 0, PMADDR_VICTIM = 1, ADMUX_ARRAY = 0, ADMUX_PMDR = 1.
- One sub-module, sat_counter (parameterised width, inc, rst), instantiated three times.

Test Plan:
- Read hit: mem_read = 1, hit = 1 in LOOKUP -> mem_resp high exactly cycle 2, lru_load = 1 same cycle, no pmem activity, hit_count = 1.
- Clean read miss: hit = 0, eviction = 0, pmem_resp after 3 FETCH cycles -> pmem_read high 3 cycles with pmemaddrmux_sel = 0; INSTALL has array_load = 1, dirty_load = 1, datawritemux_sel = 0; replay hit gives mem_resp at cycle 7; miss_count = 1, hit_count = 0.
- Dirty write miss: mem_write = 1, hit = 0, eviction = 1 -> pmem_write with pmemaddrmux_sel = 1 until pmem_resp, then FETCH/INSTALL; replay LOOKUP asserts array_load = 1, datawritemux_sel = 1, dirty_load = 1, mem_resp = 1; wb_count = 1.
- Write hit: mem_write = 1, hit = 1 -> single cycle with array_load, dirty_load, lru_load, mem_resp all 1 and datawritemux_sel = 1.
- Reset mid-FETCH: rst = 1 for one cycle during pmem_read -> next cycle state IDLE, pmem_read = 0, counters 0, no mem_resp.
- Counter saturation (CNT_WIDTH = 4): 17 read hits -> hit_count holds 4'hF.
